// File: rtl/warp_register_file.sv
// Per-warp, per-lane register file: one write port, two registered read ports.
// Reads use write-first bypass. After reset, a clear sequencer zeroes every entry before ready rises.
module warp_register_file #(
  parameter int unsigned NUM_LANES      = 16,
  parameter int unsigned NUM_WARPS      = 8,
  parameter int unsigned NUM_REGS       = 64,
  parameter int unsigned DATA_W         = 64,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter int unsigned WARP_W         = $clog2(NUM_WARPS),
  parameter int unsigned ADDR_W         = $clog2(NUM_REGS)
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          ready,
  input  logic [NUM_LANES-1:0]          write_en,
  input  logic [WARP_W-1:0]             wwarp,
  input  logic [ADDR_W-1:0]             waddr,
  input  logic [NUM_LANES*DATA_W-1:0]   wdata,
  input  logic [NUM_LANES-1:0]          read_en_0,
  input  logic [WARP_W-1:0]             rwarp_0,
  input  logic [ADDR_W-1:0]             raddr_0,
  output logic [NUM_LANES*DATA_W-1:0]   rdata_0,
  output logic [NUM_LANES-1:0]          rvalid_0,
  input  logic [NUM_LANES-1:0]          read_en_1,
  input  logic [WARP_W-1:0]             rwarp_1,
  input  logic [ADDR_W-1:0]             raddr_1,
  output logic [NUM_LANES*DATA_W-1:0]   rdata_1,
  output logic [NUM_LANES-1:0]          rvalid_1
);

  localparam int unsigned IDX_W  = WARP_W + ADDR_W;
  localparam int unsigned DEPTH  = NUM_WARPS * NUM_REGS;
  localparam int unsigned NPORTS = 2;

  typedef enum logic {ST_CLEAR, ST_READY} state_e;

  state_e                                     state_q;
  logic [IDX_W-1:0]                           clr_cnt_q;
  logic                                       ready_q;
  logic [DATA_W-1:0]                          mem_q [DEPTH][NUM_LANES];
  logic [NPORTS-1:0][NUM_LANES*DATA_W-1:0]    rdata_q;
  logic [NPORTS-1:0][NUM_LANES-1:0]           rvalid_q;

  logic [IDX_W-1:0]                           w_idx;
  logic [NPORTS-1:0][IDX_W-1:0]               rd_idx;
  logic [NPORTS-1:0][NUM_LANES-1:0]           rd_en;
  logic                                       clear_act;
  logic                                       wr_act;

  assign w_idx     = {wwarp, waddr};
  assign rd_idx[0] = {rwarp_0, raddr_0};
  assign rd_idx[1] = {rwarp_1, raddr_1};
  assign rd_en[0]  = read_en_0;
  assign rd_en[1]  = read_en_1;
  assign clear_act = !rst && (state_q == ST_CLEAR);
  assign wr_act    = !rst && ready_q;

  // Clear sequencer: one {warp,reg} entry per cycle, then ready
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + IDX_W'(1);
          if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
            state_q <= ST_READY;
            ready_q <= 1'b1;
          end
        end
        ST_READY: ready_q <= 1'b1;
        default:  state_q <= ST_READY;
      endcase
    end
  end

  // Storage: clear writes zero in every lane and takes precedence over the write port
  always_ff @(posedge clk) begin
    for (int l = 0; l < NUM_LANES; l++) begin
      if (clear_act) begin
        mem_q[clr_cnt_q][l] <= '0;
      end else if (wr_act && write_en[l]) begin
        mem_q[w_idx][l] <= wdata[l*DATA_W +: DATA_W];
      end
    end
  end

  // Registered read ports; a same-edge write to the same entry and lane is forwarded
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        for (int l = 0; l < NUM_LANES; l++) begin
          if (ready_q && rd_en[p][l]) begin
            rvalid_q[p][l] <= 1'b1;
            if (write_en[l] && (w_idx == rd_idx[p])) begin
              rdata_q[p][l*DATA_W +: DATA_W] <= wdata[l*DATA_W +: DATA_W];
            end else begin
              rdata_q[p][l*DATA_W +: DATA_W] <= mem_q[rd_idx[p]][l];
            end
          end else begin
            rvalid_q[p][l]                 <= 1'b0;
            rdata_q[p][l*DATA_W +: DATA_W] <= '0;
          end
        end
      end
    end
  end

  assign ready    = ready_q;
  assign rdata_0  = rdata_q[0];
  assign rvalid_0 = rvalid_q[0];
  assign rdata_1  = rdata_q[1];
  assign rvalid_1 = rvalid_q[1];

endmodule
